// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator floor-dispatch slice.
package elevador_pkg;

    localparam int unsigned FLOORS  = 5;
    localparam int unsigned FLOOR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        ARRIVE,
        DOOR_REQ,
        DOOR_WAIT
    } state_t;

endpackage

// File: rtl/elevador_req_scan.sv
// Classifies latched calls relative to the car: at this floor, ahead of or behind the scan.
module elevador_req_scan
    import elevador_pkg::*;
#(
    parameter int unsigned FLOORS  = elevador_pkg::FLOORS,
    parameter int unsigned FLOOR_W = elevador_pkg::FLOOR_W
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               dir_up,
    output logic               req_here,
    output logic               req_ahead,
    output logic               req_behind
);

    logic req_above;
    logic req_below;

    // Reduce pending calls strictly above and strictly below the current floor.
    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor) begin
                req_above = req_above | pending[i];
            end
            if (FLOOR_W'(i) < floor) begin
                req_below = req_below | pending[i];
            end
        end
    end

    // Map above/below onto the scan direction.
    always_comb begin
        req_here   = pending[floor];
        req_ahead  = dir_up ? req_above : req_below;
        req_behind = dir_up ? req_below : req_above;
    end

endmodule

// File: rtl/elevador_floor_ctrl.sv
// Floor-dispatch controller: latches calls, scans floor by floor, hands door cycles to the door block.
module elevador_floor_ctrl
    import elevador_pkg::*;
#(
    parameter int unsigned FLOORS     = elevador_pkg::FLOORS,
    parameter int unsigned MOVE_TICKS = 4,
    parameter int unsigned FLOOR_W    = elevador_pkg::FLOOR_W
) (
    input  logic               clk,
    input  logic               rst_a_p,
    input  logic               tick_en,
    input  logic [FLOORS-1:0]  call_btn,
    input  logic               door_busy,
    output logic               door_req,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  floor_led,
    output logic [FLOORS-1:0]  pending,
    output logic               dir_up,
    output logic               moving
);

    localparam int unsigned        CNT_W     = $clog2(MOVE_TICKS + 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MOVE_TICKS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [FLOOR_W-1:0] floor_q;
    logic [FLOOR_W-1:0] floor_step;
    logic [FLOORS-1:0]  pend_q;
    logic [FLOORS-1:0]  pend_nxt;
    logic [FLOORS-1:0]  here_oh;
    logic [FLOORS-1:0]  call_acc;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               step;
    logic               serve;
    logic               req_here;
    logic               req_ahead;
    logic               req_behind;

    elevador_req_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_req_scan (
        .pending    (pend_q),
        .floor      (floor_q),
        .dir_up     (dir_q),
        .req_here   (req_here),
        .req_ahead  (req_ahead),
        .req_behind (req_behind)
    );

    // One-hot decode of the current floor, shared by the LED output and call clearing.
    always_comb begin
        here_oh          = '0;
        here_oh[floor_q] = 1'b1;
    end

    // Travel strobe and saturating next-floor value.
    always_comb begin
        step       = (state == MOVE) && tick_en && (cnt_q == CNT_LAST);
        floor_step = floor_q;
        if (dir_q) begin
            if (floor_q != TOP_FLOOR) begin
                floor_step = floor_q + 1'b1;
            end
        end else begin
            if (floor_q != '0) begin
                floor_step = floor_q - 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_a_p) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the collective scan.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_here) begin
                    state_nxt = DOOR_REQ;
                end else if (req_ahead) begin
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (step) begin
                    state_nxt = ARRIVE;
                end
            end
            ARRIVE: begin
                if (req_here) begin
                    state_nxt = DOOR_REQ;
                end else if (req_ahead) begin
                    state_nxt = MOVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOOR_REQ: begin
                if (door_busy) begin
                    state_nxt = DOOR_WAIT;
                end
            end
            DOOR_WAIT: begin
                if (!door_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        door_req = (state == DOOR_REQ);
        moving   = (state == MOVE);
    end

    // Call latch: the floor being served clears its bit on DOOR_REQ entry (clear beats a same-cycle set),
    // and presses for the current floor are ignored while the door is already cycling.
    always_comb begin
        serve    = (state_nxt == DOOR_REQ) && (state != DOOR_REQ);
        call_acc = call_btn;
        if ((state == DOOR_REQ) || (state == DOOR_WAIT)) begin
            call_acc = call_btn & ~here_oh;
        end
        pend_nxt = pend_q | call_acc;
        if (serve) begin
            pend_nxt = pend_nxt & ~here_oh;
        end
    end

    // Datapath registers: calls, travel counter, floor position and scan direction.
    always_ff @(posedge clk) begin
        if (!rst_a_p) begin
            pend_q  <= '0;
            cnt_q   <= '0;
            floor_q <= '0;
            dir_q   <= 1'b1;
        end else begin
            pend_q <= pend_nxt;
            if ((state == MOVE) && tick_en) begin
                cnt_q <= step ? '0 : cnt_q + 1'b1;
            end
            if (step) begin
                floor_q <= floor_step;
            end
            // Reversal happens in IDLE one cycle before the move; an idle car at an
            // end floor parks its direction pointing back into the shaft.
            if ((state == IDLE) && !req_here && !req_ahead) begin
                if (req_behind) begin
                    dir_q <= ~dir_q;
                end else if (floor_q == '0) begin
                    dir_q <= 1'b1;
                end else if (floor_q == TOP_FLOOR) begin
                    dir_q <= 1'b0;
                end
            end
        end
    end

    assign floor     = floor_q;
    assign floor_led = here_oh;
    assign pending   = pend_q;
    assign dir_up    = dir_q;

endmodule

// File: tb/tb_elevador_floor_ctrl.sv
// Directed bench for elevador_floor_ctrl with a behavioural door handshake.
module tb_elevador_floor_ctrl;

    logic       clk       = 1'b0;
    logic       rst_a_p   = 1'b0;
    logic       tick_en   = 1'b0;
    logic [4:0] call_btn  = '0;
    logic       door_busy = 1'b0;
    logic       door_req;
    logic [2:0] floor;
    logic [4:0] floor_led;
    logic [4:0] pending;
    logic       dir_up;
    logic       moving;

    int   nvec = 0;
    int   nerr = 0;

    logic       mon_on     = 1'b0;
    logic       tick_phase = 1'b0;
    logic [2:0] last_floor = '0;
    int         tk_cnt     = 0;

    elevador_floor_ctrl #(
        .FLOORS     (5),
        .MOVE_TICKS (4),
        .FLOOR_W    (3)
    ) dut (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .tick_en   (tick_en),
        .call_btn  (call_btn),
        .door_busy (door_busy),
        .door_req  (door_req),
        .floor     (floor),
        .floor_led (floor_led),
        .pending   (pending),
        .dir_up    (dir_up),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tick every other clock; on each floor change check step size, tick count and LED decode.
    always @(negedge clk) begin
        logic [4:0] led_exp;
        logic [2:0] delta;
        if (floor != last_floor) begin
            if (mon_on) begin
                led_exp = 5'b00001 << floor;
                delta   = (floor > last_floor) ? floor - last_floor : last_floor - floor;
                chk_vec("step_ticks", tk_cnt, 4);
                chk_vec("step_size", 32'(delta), 1);
                chk_vec("step_led", 32'(floor_led), 32'(led_exp));
            end
            last_floor = floor;
            tk_cnt     = 0;
        end
        tick_phase = ~tick_phase;
        tick_en    = tick_phase;
        if (tick_en && moving) tk_cnt++;
    end

    task automatic pulse_call(input logic [4:0] btn);
        @(negedge clk) call_btn = btn;
        @(negedge clk) call_btn = '0;
    endtask

    task automatic wait_floor(input logic [2:0] f, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (floor == f) break;
        end
        chk_vec(tag, 32'(floor), 32'(f));
    endtask

    task automatic wait_moving(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (moving) break;
        end
        chk_vec(tag, 32'(moving), 1);
    endtask

    // Wait for a door request, check where it happened, then play the door block.
    task automatic serve(input logic [2:0] exp_floor, input logic [4:0] exp_pend, input logic exp_dir);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (door_req) break;
        end
        chk_vec("serve_req", 32'(door_req), 1);
        if (!door_req) return;
        chk_vec("serve_floor", 32'(floor), 32'(exp_floor));
        chk_vec("serve_pend", 32'(pending), 32'(exp_pend));
        chk_vec("serve_dir", 32'(dir_up), 32'(exp_dir));
        chk_vec("serve_still", 32'(moving), 0);
        door_busy = 1'b1;
        @(negedge clk);
        chk_vec("serve_req_drop", 32'(door_req), 0);
        door_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic quiet_check(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (door_req) seen = 1'b1;
        end
        chk_vec(tag, 32'(seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp_p;

        // Reset state
        repeat (3) @(negedge clk);
        chk_vec("rst_floor", 32'(floor), 0);
        chk_vec("rst_led", 32'(floor_led), 32'h01);
        chk_vec("rst_pend", 32'(pending), 0);
        chk_vec("rst_dir", 32'(dir_up), 1);
        chk_vec("rst_req", 32'(door_req), 0);
        chk_vec("rst_moving", 32'(moving), 0);
        rst_a_p = 1'b1;
        mon_on  = 1'b1;

        // Call at the current floor, door busy 3 clk, press again during DOOR_WAIT
        @(negedge clk) call_btn = 5'b00001;
        @(negedge clk) call_btn = '0;
        chk_vec("t1_pend_latch", 32'(pending), 32'h01);
        chk_vec("t1_req_early", 32'(door_req), 0);
        @(negedge clk);
        chk_vec("t1_door_req", 32'(door_req), 1);
        chk_vec("t1_floor", 32'(floor), 0);
        chk_vec("t1_pend_clr", 32'(pending), 0);
        chk_vec("t1_moving", 32'(moving), 0);
        @(negedge clk);
        chk_vec("t1_req_hold", 32'(door_req), 1);
        door_busy = 1'b1;
        @(negedge clk);
        chk_vec("t1_req_drop", 32'(door_req), 0);
        call_btn = 5'b00001;
        @(negedge clk) call_btn = '0;
        @(negedge clk) door_busy = 1'b0;
        chk_vec("t4_pend_drop", 32'(pending), 0);
        @(negedge clk);
        chk_vec("t1_idle_pend", 32'(pending), 0);
        chk_vec("t1_idle_moving", 32'(moving), 0);
        quiet_check(10, "t4_no_second_req");

        // Travel to 4, add calls 0 and 1 while passing 2, serve 4 then 1 then 0
        pulse_call(5'b10000);
        chk_vec("t2_pend", 32'(pending), 32'h10);
        wait_moving("t2_start");
        chk_vec("t2_dir", 32'(dir_up), 1);
        wait_floor(3'd2, "t3_reach2");
        pulse_call(5'b00011);
        chk_vec("t3_pend", 32'(pending), 32'h13);
        serve(3'd4, 5'b00011, 1'b1);
        serve(3'd1, 5'b00001, 1'b0);
        serve(3'd0, 5'b00000, 1'b0);
        repeat (3) @(negedge clk);
        chk_vec("t3_dir_park0", 32'(dir_up), 1);

        // Reset mid-travel 2->3 with a call in flight
        pulse_call(5'b10000);
        wait_floor(3'd2, "t5_reach2");
        repeat (2) @(negedge clk);
        chk_vec("t5_mid_move", 32'(moving), 1);
        mon_on   = 1'b0;
        rst_a_p  = 1'b0;
        call_btn = 5'b01000;
        @(negedge clk);
        rst_a_p  = 1'b1;
        call_btn = '0;
        chk_vec("t5_floor", 32'(floor), 0);
        chk_vec("t5_led", 32'(floor_led), 32'h01);
        chk_vec("t5_pend", 32'(pending), 0);
        chk_vec("t5_req", 32'(door_req), 0);
        chk_vec("t5_dir", 32'(dir_up), 1);
        chk_vec("t5_moving", 32'(moving), 0);
        repeat (3) @(negedge clk);
        chk_vec("t5_stay_idle", 32'(moving), 0);
        mon_on = 1'b1;

        // Reset glitch between clock edges while moving
        pulse_call(5'b00100);
        wait_moving("t5g_start");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_a_p = 1'b0;
        #2 rst_a_p = 1'b1;
        @(negedge clk);
        chk_vec("t5g_moving", 32'(moving), 1);
        chk_vec("t5g_pend", 32'(pending), 32'h04);
        chk_vec("t5g_floor", 32'(floor), 0);
        serve(3'd2, 5'b00000, 1'b1);

        // All five calls at once from floor 0
        mon_on  = 1'b0;
        rst_a_p = 1'b0;
        @(negedge clk) rst_a_p = 1'b1;
        @(negedge clk) mon_on = 1'b1;
        pulse_call(5'b11111);
        chk_vec("t6_pend_all", 32'(pending), 32'h1F);
        for (int k = 0; k < 5; k++) begin
            exp_p = 5'b11111;
            exp_p = exp_p << (k + 1);
            serve(3'(k), exp_p, 1'b1);
        end
        quiet_check(20, "t6_no_extra_req");
        chk_vec("t6_final_floor", 32'(floor), 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/elevador_floor_ctrl.md
Name: elevador_floor_ctrl

Overview:
Floor-dispatch controller for the 5-floor elevator. It sits directly upstream of the door-sequencing block.
- Latches hall/car call buttons and moves the car floor by floor using a collective-scan policy.
- On arrival at a requested floor, handshakes a door-cycle request to the door block and waits for it to finish before moving again.
- Drives floor position and direction indicators for the board.

Parameters:
FLOORS, 5, number of floors; floor index 0..FLOORS-1.
MOVE_TICKS, 4, tick_en pulses spent travelling between adjacent floors (>=1).
FLOOR_W, 3, width of the binary floor index (ceil(log2(FLOORS))).

Ports:
clk  input  1  system clock.
rst_a_p  input  1  reset, synchronous, active-low. Sampled only on posedge clk.
tick_en  input  1  one-clk-wide travel-time strobe (2 Hz from clkdiv); gates the travel counter only.
call_btn  input  FLOORS  debounced call requests, one bit per floor; level or pulse accepted.
door_busy  input  1  high while the door block is outside its closed/idle state.
door_req  output  1  door-cycle request; held high until door_busy is seen high.
floor  output  FLOOR_W  current floor, binary.
floor_led  output  FLOORS  current floor, one-hot.
pending  output  FLOORS  latched, unserved calls.
dir_up  output  1  1 = scanning up, 0 = scanning down.
moving  output  1  high in MOVE state.

Behaviour:
- Reset (rst_a_p=0 at posedge clk):
  - state=IDLE, floor=0, floor_led=00001, pending=0, dir_up=1, door_req=0, moving=0, travel counter=0.
  - Reset mid-travel or mid-door-cycle abandons the operation; the car snaps logically to floor 0.
- Call latch: pending[i] is set on the clk after call_btn[i]=1. It is cleared only when floor i is served, i.e. on entry to DOOR_REQ at floor i. Set and clear in the same cycle: clear wins, and the call is considered served.
- "Ahead" = any pending bit strictly above floor when dir_up=1, or strictly below when dir_up=0. "Behind" = the opposite side.
- IDLE:
  - If pending[floor]=1, go to DOOR_REQ.
  - Else if requests are ahead, go to MOVE.
  - Else if requests are behind, toggle dir_up and go to MOVE the following cycle.
  - Else stay in IDLE.
  - Decision latency from call latch: 1 clk.
- MOVE:
  - moving=1. Count tick_en pulses. At the MOVE_TICKS-th pulse, floor += dir_up?1:-1 and the counter clears; go to ARRIVE.
  - floor never leaves 0..FLOORS-1. At floor 0 dir_up is forced 1; at FLOORS-1 it is forced 0.
- ARRIVE (1 clk):
  - If pending[floor], go to DOOR_REQ.
  - Else if requests are ahead, go to MOVE.
  - Else go to IDLE; IDLE re-evaluates reversal.
- DOOR_REQ: door_req=1 and pending[floor] is cleared on entry. Stay until door_busy=1, then go to DOOR_WAIT with door_req=0.
- DOOR_WAIT:
  - Stay while door_busy=1. On door_busy=0, go to IDLE.
  - New calls for the current floor arriving during DOOR_REQ/DOOR_WAIT are dropped; the door is already cycling.
- Simultaneous calls are all latched; service order follows the scan direction.
- tick_en is ignored outside MOVE.
- The counter width is ceil(log2(MOVE_TICKS+1)).
- floor_led is always the one-hot decode of floor (combinational).

Decomposition:
- Shared package elevador_pkg holds:
  - state encoding IDLE, MOVE, ARRIVE, DOOR_REQ, DOOR_WAIT;
  - FLOORS and FLOOR_W.
- One natural sub-module, elevador_req_scan: a combinational block that takes pending, floor and dir_up and produces req_here, req_ahead and req_behind.

Test Plan:
1. Reset, then call_btn=00001 pulse → door_req=1 at clk+2, floor=0, moving stays 0. door_busy high 3 clk then low → return to IDLE, pending=0.
2. MOVE_TICKS=4, call_btn=10000 from floor 0 → moving=1. floor steps 1,2,3,4, one step every 4 tick_en pulses. door_req=1 at floor 4, dir_up stays 1.
3. Car at 2 moving up, pending=00011|10000 → serve 3? No: serve 4 first, then reverse (dir_up=0) and serve 1, then 0. Check floor and door_req sequence 4,1,0.
4. call_btn[floor] asserted during DOOR_WAIT → pending stays 0, no second door_req.
5. rst_a_p=0 mid-MOVE between floors 2→3 → next clk: floor=0, pending=0, door_req=0, dir_up=1. Asynchronous pulse not aligned to clk has no effect.
6. All five buttons asserted in one cycle at floor 0 → pending=11111, served in order 0,1,2,3,4, each with exactly one door_req handshake.
